alu_quad_bank: RTL and testbench
================================

Name: alu_quad_bank

Overview:
- Four-lane registered 32-bit ALU.
- Each lane (bank) independently takes a command packet (two 32-bit operands plus a 2-bit command) and returns a result packet (32-bit data plus a 2-bit response) one clock later.
- Sits between a command producer and its consumer. Banks share only the clock and reset.

Parameters:
- NUM_BANKS, 4, number of independent ALU lanes (the bench drives exactly 4).
- DATA_W, 32, operand and result width.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  one clock; reset is synchronous and active-low (reset==0 sampled at posedge clears state).
- input_packet  input  NUM_BANKS x input_packet_t (4 x 66 bits)  per-bank {data1[31:0], data2[31:0], command[1:0]}.
- output_packet  output  NUM_BANKS x output_packet_t (4 x 34 bits)  per-bank {data[31:0], response[1:0]}.

Behaviour:
- Types (shared package, visible to bench):
  - command_names_t (2-bit enum): NO_OP=0, ADD=1, SUB=2, SHIFT_LEFT=3.
  - response_names_t (2-bit enum): NO_RESPONSE=0, SUCCESS=1, OVERFLOW=2, UNDERFLOW=3.
  - Packed struct field order is as listed, MSB first.
- Reset:
  - At posedge with reset==0, every bank sets data=0 and response=NO_RESPONSE.
  - Reset overrides any command in flight. The cycle after reset is released, a bank processes the command present on its input.
- Timing:
  - Per bank, per posedge with reset==1, the command sampled at that edge produces its result registered at the same edge.
  - Latency is 1 cycle; throughput is 1 command per cycle per bank.
  - No handshake: the command is re-executed every cycle while held.
- NO_OP: data holds its previous value; response=NO_RESPONSE.
- ADD, unsigned:
  - data = (data1+data2)[31:0].
  - response = OVERFLOW if carry-out, else SUCCESS.
- SUB, unsigned:
  - data = (data1-data2)[31:0], wraps modulo 2^32.
  - response = UNDERFLOW if data2>data1, else SUCCESS.
- SHIFT_LEFT:
  - data = data1 << data2[4:0]; upper bits of data2 are ignored; shift of 0 passes data1 unchanged.
  - response = OVERFLOW if any 1 bit is shifted out, else SUCCESS.
- Banks are fully independent: a command or result in one bank never affects another bank. Simultaneous commands on all 4 banks complete on the same edge.
- Outputs come directly from registers, with no combinational path from input_packet to output_packet.
- Unknown/X commands need not be handled; the command field is always a legal enum.

Test Plan:
- Hold reset=0 for one posedge, then release -> all 4 banks data=32'h0, response=NO_RESPONSE.
- Bank0 ADD data1=5, data2=7 -> next edge data=12, SUCCESS. Then ADD FFFFFFFF+00000001 -> data=0, OVERFLOW.
- Bank1 SUB 3-5 -> data=FFFFFFFE, UNDERFLOW. SUB 10-4 -> data=6, SUCCESS.
- Bank2 SHIFT_LEFT 1<<31 -> 80000000, SUCCESS. 3<<31 -> 80000000, OVERFLOW. data2=32'h20 (shift 0) -> data1 unchanged, SUCCESS.
- All banks at once: ADD, SUB, SHIFT_LEFT, NO_OP with random operands -> each bank matches its own reference model on the same edge; the NO_OP bank holds its prior data with NO_RESPONSE.
- Reset asserted while banks hold ADD results -> next edge all data=0, NO_RESPONSE. After release, a held ADD command recomputes its result the following edge.

Source files
------------

// File: rtl/alu_quad_bank.sv
// Four independent registered 32-bit ALU lanes: ADD / SUB / SHIFT_LEFT / NO_OP with status response.
// Latency 1 cycle, throughput 1 command per cycle per lane; no backpressure, a held command re-executes every cycle.
package alu_quad_bank_pkg;
  typedef enum logic [1:0] {
    NO_OP      = 2'd0,
    ADD        = 2'd1,
    SUB        = 2'd2,
    SHIFT_LEFT = 2'd3
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    UNDERFLOW   = 2'd3
  } response_names_t;

  typedef struct packed {
    logic [31:0]    data1;
    logic [31:0]    data2;
    command_names_t command;
  } input_packet_t;

  typedef struct packed {
    logic [31:0]     data;
    response_names_t response;
  } output_packet_t;
endpackage

module alu_quad_bank
  import alu_quad_bank_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  input_packet_t  [NUM_BANKS-1:0]  input_packet,
  output output_packet_t [NUM_BANKS-1:0]  output_packet
);

  localparam int SH_W = $clog2(DATA_W);

  output_packet_t [NUM_BANKS-1:0] bank_nxt;

  // One lane's next state; prev supplies the held data for NO_OP.
  function automatic output_packet_t compute(input input_packet_t ip, input output_packet_t prev);
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] shifted;
    output_packet_t      res;
    sum     = {1'b0, ip.data1} + {1'b0, ip.data2};
    diff    = {1'b0, ip.data1} - {1'b0, ip.data2};
    shifted = {{DATA_W{1'b0}}, ip.data1} << ip.data2[SH_W-1:0];
    res          = prev;
    res.response = NO_RESPONSE;
    case (ip.command)
      ADD: begin
        res.data     = sum[DATA_W-1:0];
        res.response = sum[DATA_W] ? OVERFLOW : SUCCESS;
      end
      SUB: begin
        // Borrow out of the extended subtract is exactly data2 > data1.
        res.data     = diff[DATA_W-1:0];
        res.response = diff[DATA_W] ? UNDERFLOW : SUCCESS;
      end
      SHIFT_LEFT: begin
        res.data     = shifted[DATA_W-1:0];
        res.response = (|shifted[2*DATA_W-1:DATA_W]) ? OVERFLOW : SUCCESS;
      end
      default: ;
    endcase
    return res;
  endfunction

  always_comb begin
    bank_nxt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_nxt[b] = compute(input_packet[b], output_packet[b]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      output_packet <= '0;
    end else begin
      output_packet <= bank_nxt;
    end
  end

endmodule

// File: tb/tb_alu_quad_bank.sv
// Randomised and directed self-check of alu_quad_bank against an arithmetic reference model.
module tb_alu_quad_bank;
  import alu_quad_bank_pkg::*;

  logic clock;
  logic reset;
  input_packet_t  [3:0] in_pkt;
  output_packet_t [3:0] out_pkt;

  logic [31:0]     exp_data [4];
  response_names_t exp_resp [4];

  int vectors;
  int miscompares;

  alu_quad_bank #(.NUM_BANKS(4), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .input_packet  (in_pkt),
    .output_packet (out_pkt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: plain wide arithmetic on the values present at the edge.
  task automatic apply_model();
    longint unsigned a, d, w;
    for (int b = 0; b < 4; b++) begin
      a = longint'(in_pkt[b].data1);
      d = longint'(in_pkt[b].data2);
      if (!reset) begin
        exp_data[b] = 32'h0;
        exp_resp[b] = NO_RESPONSE;
      end else begin
        case (in_pkt[b].command)
          NO_OP: exp_resp[b] = NO_RESPONSE;
          ADD: begin
            w = a + d;
            exp_data[b] = w[31:0];
            exp_resp[b] = (w > 64'hFFFF_FFFF) ? OVERFLOW : SUCCESS;
          end
          SUB: begin
            w = a - d;
            exp_data[b] = w[31:0];
            exp_resp[b] = (d > a) ? UNDERFLOW : SUCCESS;
          end
          default: begin
            w = a << (d % 32);
            exp_data[b] = w[31:0];
            exp_resp[b] = ((w >> 32) != 0) ? OVERFLOW : SUCCESS;
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    apply_model();
    #1;
  endtask

  task automatic set_cmd(input int b, input command_names_t c, input logic [31:0] a, input logic [31:0] d);
    in_pkt[b].command = c;
    in_pkt[b].data1   = a;
    in_pkt[b].data2   = d;
  endtask

  task automatic idle_all();
    for (int b = 0; b < 4; b++) set_cmd(b, NO_OP, $urandom, $urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int b = 0; b < 4; b++) set_cmd(b, ADD, $urandom, $urandom);
    tick();
    reset = 1'b1;
    idle_all();
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (out_pkt[b].data !== 32'h0 || out_pkt[b].response !== NO_RESPONSE) begin
        miscompares++;
        $display("FAIL reset bank%0d: got %h/%0d expected 00000000/%0d",
                 b, out_pkt[b].data, out_pkt[b].response, NO_RESPONSE);
      end
    end
  endtask

  // Applies one command on bank b (others idle) and checks against fixed expected values.
  task automatic directed(input string name, input int b, input command_names_t c,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] want_d, input response_names_t want_r);
    idle_all();
    set_cmd(b, c, a, d);
    tick();
    vectors++;
    if (out_pkt[b].data !== want_d || out_pkt[b].response !== want_r) begin
      miscompares++;
      $display("FAIL %s bank%0d: got %h/%0d expected %h/%0d",
               name, b, out_pkt[b].data, out_pkt[b].response, want_d, want_r);
    end
    for (int o = 0; o < 4; o++) begin
      if (o != b) begin
        vectors++;
        if (out_pkt[o].data !== exp_data[o] || out_pkt[o].response !== exp_resp[o]) begin
          miscompares++;
          $display("FAIL %s_isolation bank%0d: got %h/%0d expected %h/%0d",
                   name, o, out_pkt[o].data, out_pkt[o].response, exp_data[o], exp_resp[o]);
        end
      end
    end
  endtask

  task automatic test_add();
    directed("add_5_7",   0, ADD, 32'd5,         32'd7,  32'd12,        SUCCESS);
    directed("add_carry", 0, ADD, 32'hFFFF_FFFF, 32'd1,  32'h0,         OVERFLOW);
  endtask

  task automatic test_sub();
    directed("sub_3_5",   1, SUB, 32'd3,  32'd5, 32'hFFFF_FFFE, UNDERFLOW);
    directed("sub_10_4",  1, SUB, 32'd10, 32'd4, 32'd6,         SUCCESS);
    directed("sub_equal", 1, SUB, 32'd9,  32'd9, 32'd0,         SUCCESS);
  endtask

  task automatic test_shift();
    directed("shl_1_31",  2, SHIFT_LEFT, 32'd1,         32'd31,  32'h8000_0000, SUCCESS);
    directed("shl_3_31",  2, SHIFT_LEFT, 32'd3,         32'd31,  32'h8000_0000, OVERFLOW);
    directed("shl_zero",  2, SHIFT_LEFT, 32'hDEAD_BEEF, 32'h20,  32'hDEAD_BEEF, SUCCESS);
    directed("shl_upper", 3, SHIFT_LEFT, 32'h0000_00F0, 32'hFFFF_FF04, 32'h0000_0F00, SUCCESS);
  endtask

  task automatic test_noop_hold();
    logic [31:0] held;
    held = out_pkt[2].data;
    directed("noop_hold", 2, NO_OP, $urandom, $urandom, held, NO_RESPONSE);
  endtask

  task automatic test_back_to_back();
    command_names_t c;
    for (int i = 0; i < 200; i++) begin
      for (int b = 0; b < 4; b++) begin
        // First quarter uses the fixed ADD/SUB/SHL/NO_OP lane mapping, then mix freely.
        c = (i < 50) ? command_names_t'((b + 1) % 4) : command_names_t'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: set_cmd(b, c, $urandom, $urandom);
          1: set_cmd(b, c, $urandom_range(0, 15), $urandom_range(0, 40));
          2: set_cmd(b, c, 32'hFFFF_FFF0 | $urandom_range(0, 15), $urandom_range(0, 31));
          default: set_cmd(b, c, $urandom_range(0, 255) << $urandom_range(0, 24), $urandom);
        endcase
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        vectors++;
        if (out_pkt[b].data !== exp_data[b] || out_pkt[b].response !== exp_resp[b]) begin
          miscompares++;
          $display("FAIL random[%0d] bank%0d cmd=%0d a=%h b=%h: got %h/%0d expected %h/%0d",
                   i, b, in_pkt[b].command, in_pkt[b].data1, in_pkt[b].data2,
                   out_pkt[b].data, out_pkt[b].response, exp_data[b], exp_resp[b]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] a [4];
    logic [31:0] d [4];
    for (int b = 0; b < 4; b++) begin
      a[b] = $urandom;
      d[b] = $urandom;
      set_cmd(b, ADD, a[b], d[b]);
    end
    tick();
    reset = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (out_pkt[b].data !== 32'h0 || out_pkt[b].response !== NO_RESPONSE) begin
        miscompares++;
        $display("FAIL midreset bank%0d: got %h/%0d expected 00000000/%0d",
                 b, out_pkt[b].data, out_pkt[b].response, NO_RESPONSE);
      end
    end
    reset = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (out_pkt[b].data !== a[b] + d[b] || out_pkt[b].response !== exp_resp[b]) begin
        miscompares++;
        $display("FAIL post_reset_add bank%0d: got %h/%0d expected %h/%0d",
                 b, out_pkt[b].data, out_pkt[b].response, a[b] + d[b], exp_resp[b]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    in_pkt      = '0;
    for (int b = 0; b < 4; b++) begin
      exp_data[b] = 32'h0;
      exp_resp[b] = NO_RESPONSE;
    end
    #1;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_noop_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
